// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle: pixel enable in, sync/enable/coordinate/strobe outputs.
interface vga_timing_gen_if #(
  parameter int ADDR_W = 11
);
  logic              pix_ce;
  logic              hsync;
  logic              vsync;
  logic              de;
  logic [ADDR_W-1:0] x;
  logic [ADDR_W-1:0] y;
  logic              win_de;
  logic [ADDR_W-1:0] win_x;
  logic [ADDR_W-1:0] win_y;
  logic              line_start;
  logic              frame_start;

  modport master (
    input  pix_ce,
    output hsync, vsync, de, x, y, win_de, win_x, win_y, line_start, frame_start
  );

  modport slave (
    output pix_ce,
    input  hsync, vsync, de, x, y, win_de, win_x, win_y, line_start, frame_start
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator with one movable sub-window.
// All outputs are registered from the pre-increment (h,v), one clk behind the counters.
module vga_timing_gen #(
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int WIN_X    = 168,
  parameter int WIN_Y    = 112,
  parameter int WIN_W    = 304,
  parameter int WIN_H    = 256,
  parameter int ADDR_W   = 11
) (
  input  logic              clk,
  input  logic              rst,
  vga_timing_gen_if.master  bus
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int H_ACT0  = H_SYNC + H_BP;
  localparam int V_ACT0  = V_SYNC + V_BP;

  typedef logic [ADDR_W-1:0] cnt_t;
  typedef logic [ADDR_W:0]   wide_t;

  localparam cnt_t  H_LAST   = cnt_t'(H_TOTAL - 1);
  localparam cnt_t  V_LAST   = cnt_t'(V_TOTAL - 1);
  localparam cnt_t  H_SYNC_C = cnt_t'(H_SYNC);
  localparam cnt_t  V_SYNC_C = cnt_t'(V_SYNC);
  localparam cnt_t  H_ACT0_C = cnt_t'(H_ACT0);
  localparam cnt_t  V_ACT0_C = cnt_t'(V_ACT0);
  localparam cnt_t  H_ACT1_C = cnt_t'(H_ACT0 + H_ACTIVE);
  localparam cnt_t  V_ACT1_C = cnt_t'(V_ACT0 + V_ACTIVE);
  localparam cnt_t  WIN_X_C  = cnt_t'(WIN_X);
  localparam cnt_t  WIN_Y_C  = cnt_t'(WIN_Y);
  // One extra bit so WIN_X+WIN_W past the counter range cannot wrap.
  localparam wide_t WIN_X0_W = wide_t'(WIN_X);
  localparam wide_t WIN_X1_W = wide_t'(WIN_X + WIN_W);
  localparam wide_t WIN_Y0_W = wide_t'(WIN_Y);
  localparam wide_t WIN_Y1_W = wide_t'(WIN_Y + WIN_H);

  cnt_t h;
  cnt_t v;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h <= '0;
      v <= '0;
    end else if (bus.pix_ce) begin
      if (h == H_LAST) begin
        h <= '0;
        v <= (v == V_LAST) ? '0 : v + 1'b1;
      end else begin
        h <= h + 1'b1;
      end
    end
  end

  logic hsync_n, vsync_n, de_n, win_n;
  cnt_t ax, ay, x_n, y_n, wx_n, wy_n;

  // NOTE: every always_comb output gets a default first, so no path leaves
  // a variable unassigned and no latch is inferred.
  always_comb begin
    ax      = h - H_ACT0_C;
    ay      = v - V_ACT0_C;
    hsync_n = (h < H_SYNC_C) ? HS_POL : !HS_POL;
    vsync_n = (v < V_SYNC_C) ? VS_POL : !VS_POL;
    de_n    = (h >= H_ACT0_C) && (h < H_ACT1_C) && (v >= V_ACT0_C) && (v < V_ACT1_C);
    win_n   = de_n
              && ({1'b0, ax} >= WIN_X0_W) && ({1'b0, ax} < WIN_X1_W)
              && ({1'b0, ay} >= WIN_Y0_W) && ({1'b0, ay} < WIN_Y1_W);
    x_n     = '0;
    y_n     = '0;
    wx_n    = '0;
    wy_n    = '0;
    if (de_n) begin
      x_n = ax;
      y_n = ay;
    end
    if (win_n) begin
      wx_n = ax - WIN_X_C;
      wy_n = ay - WIN_Y_C;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.hsync       <= !HS_POL;
      bus.vsync       <= !VS_POL;
      bus.de          <= 1'b0;
      bus.x           <= '0;
      bus.y           <= '0;
      bus.win_de      <= 1'b0;
      bus.win_x       <= '0;
      bus.win_y       <= '0;
      bus.line_start  <= 1'b0;
      bus.frame_start <= 1'b0;
    end else begin
      // Strobes clear on any edge without pix_ce, keeping them one clk wide.
      bus.line_start  <= bus.pix_ce && (h == '0);
      bus.frame_start <= bus.pix_ce && (h == '0) && (v == '0);
      if (bus.pix_ce) begin
        bus.hsync  <= hsync_n;
        bus.vsync  <= vsync_n;
        bus.de     <= de_n;
        bus.x      <= x_n;
        bus.y      <= y_n;
        bus.win_de <= win_n;
        bus.win_x  <= wx_n;
        bus.win_y  <= wy_n;
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default 640x480 timing plus a small raster for
// whole-frame and window corners, and a polarity/disabled-window override.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ce  = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  vga_timing_gen_if #(.ADDR_W(11)) d_if ();
  vga_timing_gen_if #(.ADDR_W(11)) s_if ();
  vga_timing_gen_if #(.ADDR_W(11)) o_if ();
  assign d_if.pix_ce = ce;
  assign s_if.pix_ce = ce;
  assign o_if.pix_ce = ce;

  vga_timing_gen dut_d (.clk(clk), .rst(rst), .bus(d_if));

  // Small raster: H total 19 (active h 7..16), V total 13 (active v 5..10),
  // window x 3..6, y 2..4.
  vga_timing_gen #(
    .H_SYNC(4), .H_BP(3), .H_ACTIVE(10), .H_FP(2),
    .V_SYNC(2), .V_BP(3), .V_ACTIVE(6),  .V_FP(2),
    .WIN_X(3), .WIN_Y(2), .WIN_W(4), .WIN_H(3)
  ) dut_s (.clk(clk), .rst(rst), .bus(s_if));

  vga_timing_gen #(
    .H_SYNC(4), .H_BP(3), .H_ACTIVE(10), .H_FP(2),
    .V_SYNC(2), .V_BP(3), .V_ACTIVE(6),  .V_FP(2),
    .HS_POL(1'b1), .WIN_X(3), .WIN_Y(2), .WIN_W(0), .WIN_H(3)
  ) dut_o (.clk(clk), .rst(rst), .bus(o_if));

  typedef struct {
    int          n;
    logic        hs, vs, de;
    logic [10:0] x, y;
    logic        wde;
    logic [10:0] wx, wy;
    logic        ls, fs;
  } vec_t;

  vec_t vecs[17];

  function automatic vec_t mk(int n, logic hs, logic vs, logic de, int x, int y,
                              logic wde, int wx, int wy, logic ls, logic fs);
    vec_t r;
    r.n = n; r.hs = hs; r.vs = vs; r.de = de;
    r.x = 11'(x); r.y = 11'(y); r.wde = wde; r.wx = 11'(wx); r.wy = 11'(wy);
    r.ls = ls; r.fs = fs;
    return r;
  endfunction

  function automatic logic [49:0] pk(logic hs, logic vs, logic de, logic [10:0] x,
                                     logic [10:0] y, logic wde, logic [10:0] wx,
                                     logic [10:0] wy, logic ls, logic fs);
    return {hs, vs, de, x, y, wde, wx, wy, ls, fs};
  endfunction

  function automatic logic [49:0] obs_d();
    return pk(d_if.hsync, d_if.vsync, d_if.de, d_if.x, d_if.y, d_if.win_de,
              d_if.win_x, d_if.win_y, d_if.line_start, d_if.frame_start);
  endfunction

  function automatic logic [49:0] obs_s();
    return pk(s_if.hsync, s_if.vsync, s_if.de, s_if.x, s_if.y, s_if.win_de,
              s_if.win_x, s_if.win_y, s_if.line_start, s_if.frame_start);
  endfunction

  function automatic logic [49:0] obs_o();
    return pk(o_if.hsync, o_if.vsync, o_if.de, o_if.x, o_if.y, o_if.win_de,
              o_if.win_x, o_if.win_y, o_if.line_start, o_if.frame_start);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int vi;
    int hs_low, vs_low, de_cnt, ls_cnt, fs_cnt, run, max_run, x_err, exp_x, max_x;
    int s_fs, s_ls, s_de, s_win, s_vs_low, s_fs_first, s_fs_second;
    int o_hs_high, o_win;
    int ls_hi, fs_hi, ls_first, ls_second, hold_err;
    logic [49:0] prev, mask;

    // Small raster, first frame plus wrap; n = posedge count with ce=1 since release.
    vecs[0]  = mk(1,   0,0,0, 0,0, 0,0,0, 1,1);
    vecs[1]  = mk(4,   0,0,0, 0,0, 0,0,0, 0,0);
    vecs[2]  = mk(5,   1,0,0, 0,0, 0,0,0, 0,0);
    vecs[3]  = mk(20,  0,0,0, 0,0, 0,0,0, 1,0);
    vecs[4]  = mk(39,  0,1,0, 0,0, 0,0,0, 1,0);
    vecs[5]  = mk(103, 1,1,1, 0,0, 0,0,0, 0,0);
    vecs[6]  = mk(112, 1,1,1, 9,0, 0,0,0, 0,0);
    vecs[7]  = mk(113, 1,1,0, 0,0, 0,0,0, 0,0);
    vecs[8]  = mk(143, 1,1,1, 2,2, 0,0,0, 0,0);
    vecs[9]  = mk(144, 1,1,1, 3,2, 1,0,0, 0,0);
    vecs[10] = mk(185, 1,1,1, 6,4, 1,3,2, 0,0);
    vecs[11] = mk(186, 1,1,1, 7,4, 0,0,0, 0,0);
    vecs[12] = mk(201, 1,1,1, 3,5, 0,0,0, 0,0);
    vecs[13] = mk(207, 1,1,1, 9,5, 0,0,0, 0,0);
    vecs[14] = mk(217, 1,1,0, 0,0, 0,0,0, 0,0);
    vecs[15] = mk(248, 0,0,0, 0,0, 0,0,0, 1,1);
    vecs[16] = mk(249, 0,0,0, 0,0, 0,0,0, 0,0);

    // Reset state.
    rst = 1'b1;
    ce  = 1'b0;
    repeat (3) tick();
    check("reset_default", obs_d(), pk(1,1,0,0,0,0,0,0,0,0));
    check("reset_override", obs_o(), pk(0,1,0,0,0,0,0,0,0,0));

    // Continuous pix_ce: first 36 default lines (line 35 is the first visible one).
    rst = 1'b0;
    ce  = 1'b1;
    vi = 0;
    hs_low = 0; vs_low = 0; de_cnt = 0; ls_cnt = 0; fs_cnt = 0;
    run = 0; max_run = 0; x_err = 0; exp_x = 0; max_x = 0;
    s_fs = 0; s_ls = 0; s_de = 0; s_win = 0; s_vs_low = 0; s_fs_first = 0; s_fs_second = 0;
    o_hs_high = 0; o_win = 0;
    for (int n = 1; n <= 28800; n++) begin
      tick();
      if (!d_if.hsync) hs_low++;
      if (!d_if.vsync) vs_low++;
      if (d_if.line_start) ls_cnt++;
      if (d_if.frame_start) fs_cnt++;
      if (d_if.de) begin
        de_cnt++;
        run++;
        if (run > max_run) max_run = run;
        if (d_if.x != 11'(exp_x) || d_if.y != 11'd0) x_err++;
        if (int'(d_if.x) > max_x) max_x = int'(d_if.x);
        exp_x++;
      end else begin
        run = 0;
      end
      if (n <= 494) begin
        if (s_if.frame_start) begin
          s_fs++;
          if (s_fs == 1) s_fs_first = n;
          if (s_fs == 2) s_fs_second = n;
        end
        if (s_if.line_start) s_ls++;
        if (s_if.de) s_de++;
        if (s_if.win_de) s_win++;
        if (!s_if.vsync) s_vs_low++;
        if (o_if.hsync) o_hs_high++;
        if (o_if.win_de) o_win++;
      end
      if (vi < 17 && vecs[vi].n == n) begin
        check($sformatf("vec_n%0d", n), obs_s(),
              pk(vecs[vi].hs, vecs[vi].vs, vecs[vi].de, vecs[vi].x, vecs[vi].y,
                 vecs[vi].wde, vecs[vi].wx, vecs[vi].wy, vecs[vi].ls, vecs[vi].fs));
        vi++;
      end
    end
    check("vec_table_consumed", vi, 17);
    check("hsync_low_36_lines", hs_low, 96 * 36);
    check("vsync_low_clks", vs_low, 2 * 800);
    check("line_start_count", ls_cnt, 36);
    check("frame_start_count", fs_cnt, 1);
    check("de_clks_first_visible", de_cnt, 640);
    check("de_longest_run", max_run, 640);
    check("x_sequence_errors", x_err, 0);
    check("x_max", max_x, 639);
    check("small_frame_starts", s_fs, 2);
    check("small_frame_period", s_fs_second - s_fs_first, 247);
    check("small_line_starts", s_ls, 26);
    check("small_de_clks", s_de, 120);
    check("small_win_clks", s_win, 24);
    check("small_vsync_low", s_vs_low, 2 * 19 * 2);
    check("ovr_hsync_high", o_hs_high, 4 * 26);
    check("ovr_win_never", o_win, 0);

    // Move into the visible part of line 36, then reset between clock edges.
    repeat (300) tick();
    check("pre_reset_de", d_if.de, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("async_reset_default", obs_d(), pk(1,1,0,0,0,0,0,0,0,0));
    check("async_reset_small", obs_s(), pk(1,1,0,0,0,0,0,0,0,0));
    ce = 1'b0;
    repeat (2) tick();
    rst = 1'b0;

    // pix_ce toggling 1/0: the first edge is the first ce after release.
    ls_hi = 0; fs_hi = 0; ls_first = 0; ls_second = 0; hold_err = 0;
    mask = ~50'b11;
    prev = '0;
    for (int k = 1; k <= 3300; k++) begin
      ce = (k % 2 == 1);
      tick();
      if (k == 1) begin
        check("first_ce_frame_start", d_if.frame_start, 1'b1);
        check("first_ce_hsync", d_if.hsync, 1'b0);
        check("first_ce_vsync", d_if.vsync, 1'b0);
      end
      if (d_if.line_start) begin
        ls_hi++;
        if (ls_hi == 1) ls_first = k;
        if (ls_hi == 2) ls_second = k;
      end
      if (d_if.frame_start) fs_hi++;
      if (!ce && ((obs_d() & mask) != (prev & mask))) hold_err++;
      prev = obs_d();
    end
    check("toggle_line_start_clks", ls_hi, 3);
    check("toggle_line_period", ls_second - ls_first, 1600);
    check("toggle_frame_start_clks", fs_hi, 1);
    check("toggle_hold_errors", hold_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
